// File: rtl/nv_nvdla_car_sync_edge_ctl.sv
// Glitch filter + edge detector on a synchronized level, with a single-entry event slot and a saturating edge counter.
// Optional macro NV_NVDLA_CAR_SYNC_EDGE_FILTER_EN enables the FILT_LEN-sample filter FSM; otherwise filt_o is sync_i delayed by one flop.
module nv_nvdla_car_sync_edge_ctl #(
   parameter int FILT_LEN = 4,
   parameter int CNT_W    = 8
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rst,
   input  logic             sync_i,
   input  logic             cnt_clr,
   input  logic             evt_ready,
   output logic             filt_o,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic             evt_valid,
   output logic             evt_type,
   output logic             evt_ovf,
   output logic [CNT_W-1:0] evt_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic diff;
   logic flip;

   assign diff = sync_i ^ filt_o;

`ifdef NV_NVDLA_CAR_SYNC_EDGE_FILTER_EN
   localparam int FW = $clog2(FILT_LEN + 1);
   localparam logic [FW-1:0] FCNT_LAST = FW'(FILT_LEN - 1);

   typedef enum logic {STABLE = 1'b0, PEND = 1'b1} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [FW-1:0] fcnt;
   logic [FW-1:0] fcnt_nxt;

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         state <= STABLE;
         fcnt  <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      case (state)
         STABLE: begin
            if (!diff) begin
               fcnt_nxt = '0;
            end else begin
               fcnt_nxt  = FW'(1);
               state_nxt = (FILT_LEN == 1) ? STABLE : PEND;
            end
         end
         PEND: begin
            if (!diff || (fcnt == FCNT_LAST)) begin
               state_nxt = STABLE;
               fcnt_nxt  = '0;
            end else begin
               fcnt_nxt = fcnt + FW'(1);
            end
         end
         default: begin
            state_nxt = STABLE;
            fcnt_nxt  = '0;
         end
      endcase
   end

   always_comb begin
      flip = 1'b0;
      if (diff) begin
         if (state == STABLE)
            flip = (FILT_LEN == 1);
         else
            flip = (fcnt == FCNT_LAST);
      end
   end
`else
   assign flip = diff;
`endif

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         filt_o     <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         evt_valid  <= 1'b0;
         evt_type   <= 1'b0;
         evt_ovf    <= 1'b0;
         evt_cnt    <= '0;
      end else begin
         filt_o     <= filt_o ^ flip;
         rise_pulse <= flip & ~filt_o;
         fall_pulse <= flip & filt_o;

         // A full slot that is being popped this cycle can take the new edge.
         if (flip && (!evt_valid || evt_ready)) begin
            evt_valid <= 1'b1;
            evt_type  <= ~filt_o;
         end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
         end

         if (cnt_clr) begin
            evt_cnt <= '0;
            evt_ovf <= 1'b0;
         end else begin
            if (flip && (evt_cnt != CNT_MAX))
               evt_cnt <= evt_cnt + 1'b1;
            if (flip && evt_valid && !evt_ready)
               evt_ovf <= 1'b1;
         end
      end
   end

endmodule

// File: doc/nv_nvdla_car_sync_edge_ctl.md
Name: nv_nvdla_car_sync_edge_ctl

Overview:
Destination-domain consumer of a 3-flop single-bit synchronizer output. It filters glitches on the synchronized level and detects rising and falling edges. Detected edges are presented as one-cycle pulses and as a single-entry valid/ready event with a sticky overflow flag. It also keeps a saturating event counter. It sits directly downstream of the strict sync cell, in the nvdla_core_clk domain, and feeds CAR control/status logic.

Parameters:
FILT_LEN, 4, consecutive samples that disagree with the filtered level before it flips; legal range 1..15.
CNT_W, 8, width of the saturating edge-event counter.

Ports:
nvdla_core_clk  input  1  destination-domain clock.
nvdla_core_rst  input  1  synchronous active-high reset.
sync_i  input  1  synchronized level from the upstream sync cell.
cnt_clr  input  1  clears evt_cnt and evt_ovf.
evt_ready  input  1  consumer accepts the pending event.
filt_o  output  1  glitch-filtered level.
rise_pulse  output  1  one-cycle pulse on a filt_o 0->1 transition.
fall_pulse  output  1  one-cycle pulse on a filt_o 1->0 transition.
evt_valid  output  1  an edge event is pending.
evt_type  output  1  pending event type: 1 = rise, 0 = fall.
evt_ovf  output  1  sticky flag: an edge was dropped because the slot was full.
evt_cnt  output  CNT_W  saturating count of filtered edges.

Behaviour:
- Clock/reset: one clock, nvdla_core_clk. Reset nvdla_core_rst is synchronous and active-high.
- Reset values: filt_o=0, rise_pulse=0, fall_pulse=0, evt_valid=0, evt_type=0, evt_ovf=0, evt_cnt=0. Filter counter is 0 and the FSM is in STABLE.
- Reset mid-operation: any pending filter count or event is discarded. No pulse is emitted on the cycle after reset, even if sync_i=1.
- Filter FSM: two states, STABLE and PEND. Filter counter fcnt is clog2(FILT_LEN+1) bits wide.
  - STABLE, sync_i==filt_o: stay; fcnt=0.
  - STABLE, sync_i!=filt_o: fcnt=1. If FILT_LEN==1, flip filt_o at this edge and stay in STABLE. Otherwise go to PEND.
  - PEND, sync_i==filt_o: go to STABLE; fcnt=0. This is a glitch; no output change.
  - PEND, sync_i!=filt_o and fcnt==FILT_LEN-1: flip filt_o; go to STABLE; fcnt=0.
  - PEND, otherwise: fcnt+=1.
- Filter latency: filt_o flips at the FILT_LEN-th consecutive clock edge at which sync_i differs from filt_o.
- Pulses: rise_pulse and fall_pulse are registered and asserted in the same cycle filt_o takes its new value, for exactly one cycle. They are never asserted together.
- Event slot (single entry):
  - Edge, slot empty: evt_valid=1 next cycle; evt_type = new level.
  - Edge, evt_valid&&evt_ready in the same cycle: old event pops and new event loads; evt_valid stays 1.
  - Edge, evt_valid&&!evt_ready: new event dropped; evt_ovf=1 (sticky); slot contents unchanged.
  - No edge, evt_valid&&evt_ready: evt_valid=0 next cycle.
  - evt_type holds its value while evt_valid=0.
- Counter: evt_cnt increments by 1 on every filtered edge, including dropped ones. It saturates at 2^CNT_W-1 with no wrap.
- cnt_clr: sets evt_cnt=0 and evt_ovf=0 next cycle. It has priority over a simultaneous increment or overflow set; that edge is not counted and no overflow is recorded. cnt_clr does not affect the event slot or the pulses.

Optional Feature:
NV_NVDLA_CAR_SYNC_EDGE_FILTER_EN
- Defined: glitch filter FSM as specified above.
- Undefined: FSM and fcnt are removed. filt_o is a single register of sync_i (1-cycle latency) and FILT_LEN is ignored. Pulse, event, overflow and counter behaviour are unchanged.

Test Plan:
1. Reset with sync_i=1, then release -> FILT_LEN=4: filt_o=1 at the 4th edge after release, rise_pulse=1 for one cycle, evt_valid=1 with evt_type=1, evt_cnt=1.
2. sync_i high for 3 cycles then low (FILT_LEN=4) -> no filt_o change, no pulses, evt_cnt stays 0.
3. Two filtered edges with evt_ready=0 -> evt_valid=1, evt_type=1 (first edge kept), evt_ovf=1, evt_cnt=2. Then evt_ready=1 for one cycle -> evt_valid=0.
4. Edge coincident with evt_valid&&evt_ready=1 -> evt_valid stays 1, evt_type updates to the new level, evt_ovf stays 0.
5. CNT_W=2 with 5 filtered edges -> evt_cnt saturates at 3. cnt_clr in the same cycle as a 6th edge -> evt_cnt=0, evt_ovf=0.
6. Reset asserted while in PEND with fcnt=2 -> all outputs at reset values next cycle, no pulse. With the macro undefined: sync_i 0->1 -> filt_o=1 and rise_pulse one cycle later.
